// File: rtl/l_out_port_alloc_ctrl_pkg.sv
// Shared router definitions: port indices, allocator state encoding and the
// crossbar select type used by all output-port controllers.
package l_out_port_alloc_ctrl_pkg;

  localparam int PORT_N = 3;
  localparam int PORT_S = 2;
  localparam int PORT_W = 1;
  localparam int PORT_E = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  typedef logic [2:0] xbar_sel_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic is_multihot4(input logic [3:0] v);
    return (v & (v - 4'd1)) != 4'b0000;
  endfunction

endpackage

// File: rtl/l_out_port_alloc_ctrl_credit_counter.sv
// Downstream credit counter shared by the output-port controllers; saturates at
// CREDIT_DEPTH and flags a return that would exceed it.
module credit_counter #(
  parameter  int CREDIT_DEPTH = 4,
  localparam int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

  logic [CNT_W-1:0] count;

  assign nonzero  = (count != '0);
  assign overflow = inc && !dec && (count == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= FULL;
    end else begin
      unique case ({inc, dec})
        2'b10:   if (count != FULL) count <= count + 1'b1;
        2'b01:   if (count != '0)   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/l_out_port_alloc_ctrl.sv
// Local (ejection) output port allocator: wormhole lock, credit tracking, pops,
// crossbar drive. Optional statistics counters under L_ALLOC_STATS_EN.
module l_out_port_alloc_ctrl
  import l_out_port_alloc_ctrl_pkg::*;
#(
  parameter int CREDIT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rrp_grant_i,
  input  logic [2:0] rrp_cs_i,
  input  logic [3:0] flit_valid_i,
  input  logic [3:0] flit_tail_i,
  input  logic       credit_return_i,
  output logic       rr_change_order_o,
  output logic       rr_downstream_credit_o,
  output logic [2:0] xbar_sel_o,
  output logic       xbar_valid_o,
  output logic [3:0] pop_o,
  output logic       busy_o,
  output logic       proto_err_o
`ifdef L_ALLOC_STATS_EN
  ,
  output logic [15:0] pkt_count_o,
  output logic [15:0] stall_count_o
`endif
);

  alloc_state_t state, state_nxt;
  logic [3:0]   owner_q;
  xbar_sel_t    sel_q;

  logic [3:0]   cand;
  xbar_sel_t    sel;
  logic         grant_ok;
  logic         cand_valid;
  logic         cand_tail;
  logic         xfer;
  logic         tail_xfer;
  logic         multi_grant;
  logic         credit_nz;
  logic         credit_ovf;

  credit_counter #(.CREDIT_DEPTH(CREDIT_DEPTH)) u_credit (
    .clk      (clk),
    .reset    (reset),
    .inc      (credit_return_i),
    .dec      (xfer),
    .nonzero  (credit_nz),
    .overflow (credit_ovf)
  );

  // In IDLE the processor's grant is the candidate; once locked the latched owner is.
  always_comb begin
    cand        = owner_q;
    sel         = sel_q;
    grant_ok    = 1'b1;
    multi_grant = 1'b0;
    if (state == IDLE) begin
      cand        = rrp_grant_i;
      sel         = rrp_cs_i;
      grant_ok    = is_onehot4(rrp_grant_i);
      multi_grant = is_multihot4(rrp_grant_i);
    end
    cand_valid = |(cand & flit_valid_i);
    cand_tail  = |(cand & flit_tail_i);
    // Reset gates the Mealy strobes so nothing moves while it is held.
    xfer       = grant_ok && cand_valid && credit_nz && !reset;
    tail_xfer  = xfer && cand_tail;
  end

  assign pop_o                  = cand & {4{xfer}};
  assign xbar_valid_o           = xfer;
  assign xbar_sel_o             = sel;
  assign rr_change_order_o      = tail_xfer;
  assign rr_downstream_credit_o = credit_nz;
  assign busy_o                 = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (xfer && !cand_tail) state_nxt = LOCKED;
      LOCKED:  if (tail_xfer)          state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= 4'b0000;
      sel_q   <= '0;
    end else if (state == IDLE && xfer) begin
      owner_q <= rrp_grant_i;
      sel_q   <= rrp_cs_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          proto_err_o <= 1'b0;
    else if (multi_grant || credit_ovf) proto_err_o <= 1'b1;
  end

`ifdef L_ALLOC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count_o   <= 16'h0000;
      stall_count_o <= 16'h0000;
    end else begin
      if (tail_xfer) pkt_count_o <= pkt_count_o + 16'h0001;
      if (state == LOCKED && !xfer && stall_count_o != 16'hFFFF)
        stall_count_o <= stall_count_o + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_l_out_port_alloc_ctrl.sv
// Directed self-checking bench for l_out_port_alloc_ctrl (credit depth 4).
module tb_l_out_port_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rrp_grant_i;
  logic [2:0] rrp_cs_i;
  logic [3:0] flit_valid_i;
  logic [3:0] flit_tail_i;
  logic       credit_return_i;
  logic       rr_change_order_o;
  logic       rr_downstream_credit_o;
  logic [2:0] xbar_sel_o;
  logic       xbar_valid_o;
  logic [3:0] pop_o;
  logic       busy_o;
  logic       proto_err_o;
`ifdef L_ALLOC_STATS_EN
  logic [15:0] pkt_count_o;
  logic [15:0] stall_count_o;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l_out_port_alloc_ctrl #(.CREDIT_DEPTH(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .rrp_grant_i            (rrp_grant_i),
    .rrp_cs_i               (rrp_cs_i),
    .flit_valid_i           (flit_valid_i),
    .flit_tail_i            (flit_tail_i),
    .credit_return_i        (credit_return_i),
    .rr_change_order_o      (rr_change_order_o),
    .rr_downstream_credit_o (rr_downstream_credit_o),
    .xbar_sel_o             (xbar_sel_o),
    .xbar_valid_o           (xbar_valid_o),
    .pop_o                  (pop_o),
    .busy_o                 (busy_o),
    .proto_err_o            (proto_err_o)
`ifdef L_ALLOC_STATS_EN
    ,
    .pkt_count_o            (pkt_count_o),
    .stall_count_o          (stall_count_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] g, input logic [2:0] cs, input logic [3:0] v,
                       input logic [3:0] t, input logic cr);
    rrp_grant_i     = g;
    rrp_cs_i        = cs;
    flit_valid_i    = v;
    flit_tail_i     = t;
    credit_return_i = cr;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b1000, 3'd4, 4'b1000, 4'b1000, 1'b0);
    #3;
    chk("rst_pop", 32'(pop_o), 32'h0);
    chk("rst_xv", 32'(xbar_valid_o), 32'h0);
    chk("rst_chg", 32'(rr_change_order_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_err", 32'(proto_err_o), 32'h0);
    chk("rst_credit", 32'(dut.u_credit.count), 32'd4);
    chk("rst_cr_o", 32'(rr_downstream_credit_o), 32'h1);

    // Single-flit packet from N right after reset release.
    next_cycle();
    reset = 1'b0;
    #3;
    chk("t1_pop", 32'(pop_o), 32'h8);
    chk("t1_xv", 32'(xbar_valid_o), 32'h1);
    chk("t1_chg", 32'(rr_change_order_o), 32'h1);
    chk("t1_sel", 32'(xbar_sel_o), 32'd4);
    next_cycle();
    drive(4'b0010, 3'd2, 4'b0010, 4'b0000, 1'b0);
    chk("t1_busy", 32'(busy_o), 32'h0);
    chk("t1_credit", 32'(dut.u_credit.count), 32'd3);

    // 3-flit packet from W; grant moves to N mid-packet.
    #3;
    chk("t2_head_pop", 32'(pop_o), 32'h2);
    chk("t2_head_sel", 32'(xbar_sel_o), 32'd2);
    chk("t2_head_chg", 32'(rr_change_order_o), 32'h0);
    next_cycle();
    drive(4'b1000, 3'd4, 4'b1010, 4'b0000, 1'b0);
    #3;
    chk("t2_body_busy", 32'(busy_o), 32'h1);
    chk("t2_body_pop", 32'(pop_o), 32'h2);
    chk("t2_body_sel", 32'(xbar_sel_o), 32'd2);
    chk("t2_body_chg", 32'(rr_change_order_o), 32'h0);
    next_cycle();
    drive(4'b1000, 3'd4, 4'b0010, 4'b0010, 1'b0);
    #3;
    chk("t2_tail_busy", 32'(busy_o), 32'h1);
    chk("t2_tail_pop", 32'(pop_o), 32'h2);
    chk("t2_tail_chg", 32'(rr_change_order_o), 32'h1);
    next_cycle();
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b1);
    chk("t2_idle", 32'(busy_o), 32'h0);
    chk("t2_credit0", 32'(dut.u_credit.count), 32'd0);
    chk("t2_cr_o0", 32'(rr_downstream_credit_o), 32'h0);

    for (int i = 0; i < 4; i++) next_cycle();
    drive(4'b1000, 3'd1, 4'b1000, 4'b0000, 1'b0);
    chk("refill_credit", 32'(dut.u_credit.count), 32'd4);
    chk("refill_err", 32'(proto_err_o), 32'h0);

    // Drain credits mid-packet from N, then stall until one credit returns.
    for (int i = 0; i < 4; i++) next_cycle();
    #3;
    chk("t3_stall_xv", 32'(xbar_valid_o), 32'h0);
    chk("t3_stall_pop", 32'(pop_o), 32'h0);
    chk("t3_stall_cr_o", 32'(rr_downstream_credit_o), 32'h0);
    chk("t3_stall_busy", 32'(busy_o), 32'h1);
    credit_return_i = 1'b1;
    next_cycle();
    drive(4'b0000, 3'd0, 4'b1000, 4'b1000, 1'b0);
    #3;
    chk("t3_resume_xv", 32'(xbar_valid_o), 32'h1);
    chk("t3_resume_pop", 32'(pop_o), 32'h8);
    chk("t3_resume_sel", 32'(xbar_sel_o), 32'd1);
    chk("t3_resume_chg", 32'(rr_change_order_o), 32'h1);
    next_cycle();
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b1);
    chk("t3_idle", 32'(busy_o), 32'h0);

    // Simultaneous xfer and return at count 2, then overflow at count 4.
    next_cycle();
    next_cycle();
    chk("t4_credit2", 32'(dut.u_credit.count), 32'd2);
    drive(4'b0001, 3'd3, 4'b0001, 4'b0001, 1'b1);
    next_cycle();
    chk("t4_same", 32'(dut.u_credit.count), 32'd2);
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b1);
    next_cycle();
    next_cycle();
    chk("t4_full", 32'(dut.u_credit.count), 32'd4);
    chk("t4_no_err", 32'(proto_err_o), 32'h0);
    next_cycle();
    credit_return_i = 1'b0;
    chk("t4_sat", 32'(dut.u_credit.count), 32'd4);
    chk("t4_ovf_err", 32'(proto_err_o), 32'h1);
    next_cycle();
    chk("t4_sticky", 32'(proto_err_o), 32'h1);

    // Reset mid-packet from S, then a multi-bit grant.
    drive(4'b0100, 3'd5, 4'b0100, 4'b0000, 1'b0);
    next_cycle();
    chk("t5_locked", 32'(busy_o), 32'h1);
    chk("t5_credit3", 32'(dut.u_credit.count), 32'd3);
    reset = 1'b1;
    #1;
    chk("t5_rst_pop", 32'(pop_o), 32'h0);
    chk("t5_rst_xv", 32'(xbar_valid_o), 32'h0);
    chk("t5_rst_chg", 32'(rr_change_order_o), 32'h0);
    chk("t5_rst_busy", 32'(busy_o), 32'h0);
    chk("t5_rst_credit", 32'(dut.u_credit.count), 32'd4);
    chk("t5_rst_err", 32'(proto_err_o), 32'h0);
    next_cycle();
    reset = 1'b0;
    drive(4'b0110, 3'd2, 4'b0110, 4'b0110, 1'b0);
    #3;
    chk("t5_multi_pop", 32'(pop_o), 32'h0);
    chk("t5_multi_xv", 32'(xbar_valid_o), 32'h0);
    next_cycle();
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0);
    chk("t5_multi_err", 32'(proto_err_o), 32'h1);
    chk("t5_multi_busy", 32'(busy_o), 32'h0);
    chk("t5_multi_credit", 32'(dut.u_credit.count), 32'd4);

`ifdef L_ALLOC_STATS_EN
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    chk("st_rst_pkt", 32'(pkt_count_o), 32'd0);
    chk("st_rst_stall", 32'(stall_count_o), 32'd0);
    drive(4'b1000, 3'd1, 4'b1000, 4'b0000, 1'b1);
    next_cycle();
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) next_cycle();
    drive(4'b0000, 3'd0, 4'b1000, 4'b1000, 1'b1);
    next_cycle();
    drive(4'b0001, 3'd3, 4'b0001, 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) next_cycle();
    drive(4'b0000, 3'd0, 4'b0000, 4'b0000, 1'b0);
    chk("st_pkt", 32'(pkt_count_o), 32'd5);
    chk("st_stall", 32'(stall_count_o), 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l_out_port_alloc_ctrl.md
Name: l_out_port_alloc_ctrl

Overview:
- Sequencing controller for the local (ejection) output port of the NoC router.
- Consumes the one-hot grant and crossbar select produced by the local round-robin priority processor.
- Locks the output to the winning input for a whole wormhole packet (head to tail), tracks downstream credits, pops input buffers and drives the crossbar.
- Pulses the round-robin order-change strobe exactly once per completed packet.

Parameters:
- CREDIT_DEPTH, 4, downstream (local sink) buffer depth in flits; initial and maximum credit count.
- CNT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived, not overridden).

Ports:
- clk  in  1  router clock
- reset  in  1  asynchronous, active-high reset
- rrp_grant_i  in  4  one-hot grant from the round-robin processor, bit3..0 = N,S,W,E
- rrp_cs_i  in  3  crossbar select code from the round-robin processor
- flit_valid_i  in  4  head-of-buffer flit valid per input, N,S,W,E
- flit_tail_i  in  4  head-of-buffer flit is a tail flit, per input
- credit_return_i  in  1  one credit returned by the local sink this cycle
- rr_change_order_o  out  1  one-cycle strobe that rotates the round-robin registers
- rr_downstream_credit_o  out  1  credit count > 0; fed back to the processor
- xbar_sel_o  out  3  crossbar select for the local output
- xbar_valid_o  out  1  flit is transferred through the crossbar this cycle
- pop_o  out  4  dequeue strobe to the owning input buffer, one-hot or zero
- busy_o  out  1  output locked to a packet (state LOCKED)
- proto_err_o  out  1  sticky protocol error

Behaviour:
- Reset values (asynchronous): state IDLE, owner 0, sel_q 0, credits = CREDIT_DEPTH, proto_err_o 0. All strobe outputs are 0 while reset is asserted.
- Transfer condition: xfer = selected owner's flit_valid & (credits != 0).
  - pop_o = owner one-hot & xfer.
  - xbar_valid_o = xfer.
  - All are combinational (Mealy); the flit moves in the same cycle.
- State IDLE:
  - Owner candidate = rrp_grant_i; xbar_sel_o = rrp_cs_i.
  - If rrp_grant_i is one-hot and xfer occurs:
    - Latch owner and sel_q.
    - If the flit is a tail (single-flit packet): assert rr_change_order_o and stay IDLE.
    - Otherwise go to LOCKED.
  - If rrp_grant_i is zero: no action.
  - If rrp_grant_i has more than one bit set: no transfer, set proto_err_o.
- State LOCKED:
  - xbar_sel_o = sel_q; rrp_grant_i is ignored.
  - On xfer with a tail flit: assert rr_change_order_o and go to IDLE.
  - A non-tail xfer or a stall (no valid or no credit) stays in LOCKED.
  - There is no timeout.
- rr_change_order_o is high only in the tail-transfer cycle. The round-robin registers rotate at that clock edge, so new priorities apply from the next cycle.
- Credit counter:
  - Decrement on xfer; increment on credit_return_i.
  - Both in the same cycle: count unchanged.
  - Return while count == CREDIT_DEPTH with no xfer: count saturates and proto_err_o is set.
  - Decrement at 0 cannot occur, because xfer requires credits != 0.
- rr_downstream_credit_o = (credits != 0), taken from the registered count.
- busy_o = (state == LOCKED).
- Back-to-back packets: a new head may be granted in the IDLE cycle directly after a tail, giving one idle-free packet switch per cycle.
- Reset mid-packet: lock is abandoned, credits reload to CREDIT_DEPTH, no change_order strobe is generated.

Optional Feature:
- Macro: L_ALLOC_STATS_EN.
- When defined, add outputs:
  - pkt_count_o [15:0]: tails transferred, wraps at 16'hFFFF -> 0.
  - stall_count_o [15:0]: LOCKED cycles without xfer, saturates at 16'hFFFF.
  - Both reset to 0.
- When not defined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared router package holds:
  - port index constants (N=3, S=2, W=1, E=0);
  - alloc_state_t enum {IDLE, LOCKED};
  - the 3-bit crossbar select typedef.
- One sub-module, credit_counter: parameterised by CREDIT_DEPTH; provides inc, dec, nonzero and overflow outputs. It is reused by the other four output-port controllers.

Test Plan:
- Reset release, credits 4, rrp_grant_i=4'b1000 with a single valid tail flit -> pop_o=1000, xbar_valid_o=1, rr_change_order_o=1 the same cycle, state stays IDLE, credits 3.
- 3-flit packet from W (grant 0010, cs 3'd2), grant switched to 1000 mid-packet -> pop_o stays 0010, xbar_sel_o stays 2, busy_o=1 for 2 cycles, one change_order pulse on the tail only.
- Credits drained to 0 mid-packet with no returns -> xbar_valid_o=0 and rr_downstream_credit_o=0 and state LOCKED held; one credit_return_i -> transfer resumes next cycle.
- Simultaneous xfer and credit_return_i at count 2 -> count stays 2; return at count 4 with idle output -> count 4, proto_err_o=1 sticky.
- rrp_grant_i=4'b0110 in IDLE -> no pop, proto_err_o=1; reset asserted mid-packet -> outputs 0 immediately, credits 4, IDLE after release.
- With L_ALLOC_STATS_EN: 5 packets with 3 stall cycles -> pkt_count_o=5, stall_count_o=3.
